// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Word-wide data memory responder with read-modify-write sub-word stores
// Optional DMEM_ALIGN_CHECK_EN: reject misaligned or illegal-size requests with rsp_err.
module dmem_responder #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RMW = 2'd1, DONE = 2'd2} state_t;
  state_t state;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] latIdx;
  logic [1:0]    latLane;
  logic          latByte;
  logic [15:0]   latWdata;
  logic [31:0]   rmwWord;

  logic          accept, sizeLegal, isByte, isHalf, isWord, reqErr, memWe;
  logic [1:0]    lane;
  logic [AW-1:0] memIdx;
  logic [31:0]   memRd, memWdata, mergedWord, loadData;
  logic [7:0]    byteVal;
  logic [15:0]   halfVal;
  logic          unusedBits;

  assign unusedBits = ^req_addr[31:AW+2];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && reset;

  // Illegal sizes fall into the word class so the default build treats them as W.
  assign sizeLegal = !(req_size[1] && req_size[0]) && !(req_size[2] && req_size[1]);
  assign isByte    = sizeLegal && (req_size[1:0] == 2'b00);
  assign isHalf    = sizeLegal && (req_size[1:0] == 2'b01);
  assign isWord    = !isByte && !isHalf;

`ifdef DMEM_ALIGN_CHECK_EN
  assign reqErr = !sizeLegal || (isHalf && req_addr[0]) || (isWord && (req_addr[1:0] != 2'b00));
`else
  assign reqErr = 1'b0;
`endif

  always_comb begin
    if (isByte)      lane = req_addr[1:0];
    else if (isHalf) lane = {req_addr[1], 1'b0};
    else             lane = 2'b00;
  end

  // Single port: the RMW write-back owns the array address while in RMW.
  assign memIdx   = (state == RMW) ? latIdx : req_addr[AW+1:2];
  assign memRd    = mem[memIdx];
  assign memWe    = (state == RMW) || (accept && req_we && isWord && !reqErr);
  assign memWdata = (state == RMW) ? mergedWord : req_wdata;

  always_comb begin
    mergedWord = rmwWord;
    if (latByte) mergedWord[{latLane, 3'b000} +: 8]      = latWdata[7:0];
    else         mergedWord[{latLane[1], 4'b0000} +: 16] = latWdata;
  end

  always_comb begin
    byteVal = memRd[{lane, 3'b000} +: 8];
    halfVal = memRd[{lane[1], 4'b0000} +: 16];
    if (isByte)      loadData = req_size[2] ? {24'd0, byteVal} : {{24{byteVal[7]}}, byteVal};
    else if (isHalf) loadData = req_size[2] ? {16'd0, halfVal} : {{16{halfVal[15]}}, halfVal};
    else             loadData = memRd;
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memIdx] <= memWdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      latIdx    <= '0;
      latLane   <= 2'b00;
      latByte   <= 1'b0;
      latWdata  <= 16'd0;
      rmwWord   <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            latIdx   <= req_addr[AW+1:2];
            latLane  <= lane;
            latByte  <= isByte;
            latWdata <= req_wdata[15:0];
            rmwWord  <= memRd;
            if (reqErr) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && !isWord) begin
              state <= RMW;
            end else begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              if (!req_we) rsp_rdata <= loadData;
            end
          end
        end
        RMW: begin
          state     <= DONE;
          rsp_valid <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
